// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receive path.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } state_t;

  // Sized for the widest frame so one FIFO entry type serves every format.
  typedef struct packed {
    logic                     perr;
    logic                     ferr;
    logic [MAX_DATA_BITS-1:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO: the head entry is visible on rdata_o
// whenever empty_o is low; flush_i empties it but keeps a coincident push.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop, wr_en;
  logic [AW-1:0]    wr_idx;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign level_o = count_q;

  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_en  = flush_i ? push_i : do_push;
  assign wr_idx = flush_i ? '0 : wr_ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= AW'(push_i);
      count_q  <= (AW+1)'(push_i);
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and the
  // read port is masked while empty, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver with mid-bit sampling, configurable frame format and a
// show-ahead receive FIFO presented as a valid/ready stream.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          rx_i,
  input  logic                          clr_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs, rxs_prev_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, ferr_q;
  logic                 tick, half;
  logic                 frame_start, cnt_clr, shift_en, par_en, stop_en, push;
  logic                 fifo_full, fifo_empty, pop, overflow_q;
  entry_t               push_entry, head;
  logic                 unused_head;

  // Idle-high presets keep reset release from looking like a start edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], rx_i};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == LAST_CNT);
  assign half = (cnt_q == HALF_CNT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: if (rxs_prev_q && !rxs) begin
        frame_start = 1'b1;
        cnt_clr     = 1'b1;
        state_d     = START;
      end
      // Restarting the timer at the start-bit centre puts later samples mid-bit.
      START: if (half) begin
        cnt_clr = 1'b1;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        shift_en = 1'b1;
        if (bit_cnt_q == LAST_DATA) state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
      end
      PAR: if (tick) begin
        par_en  = 1'b1;
        state_d = STOP;
      end
      STOP: if (tick) begin
        stop_en = 1'b1;
        if (bit_cnt_q == LAST_STOP) begin
          push    = 1'b1;
          state_d = rxs ? IDLE : BREAK;
        end
      end
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q <= (cnt_clr || tick) ? '0 : cnt_q + 1'b1;
      if (state_d != state_q)       bit_cnt_q <= '0;
      else if (shift_en || stop_en) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (frame_start) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (shift_en) data_q <= {rxs, data_q[DATA_BITS-1:1]};
      if (par_en)   perr_q <= (PARITY == PARITY_ODD) ? ~(^data_q ^ rxs) : (^data_q ^ rxs);
      if (stop_en)  ferr_q <= ferr_q | ~rxs;
    end
  end

  // The final stop sample is folded in combinationally so the push needs no extra cycle.
  assign push_entry = '{perr: perr_q, ferr: ferr_q | ~rxs, data: MAX_DATA_BITS'(data_q)};
  assign pop        = valid_o && ready_i;

  uart_rx_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (clr_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                        overflow_q <= 1'b0;
    else if (clr_i)                      overflow_q <= 1'b0;
    else if (push && fifo_full && !pop)  overflow_q <= 1'b1;
  end

  assign valid_o     = !fifo_empty;
  assign data_o      = head.data[DATA_BITS-1:0];
  assign perr_o      = head.perr;
  assign ferr_o      = head.ferr;
  assign overflow_o  = overflow_q;
  assign unused_head = ^head.data;

endmodule
